onehot_scan_encoder: RTL

- Inverse-direction companion to the team's 3-to-8 one-hot decoder.
- Accepts an 8-bit request vector in which any number of bits may be set.
- Emits the 3-bit binary index of each set bit, one index per output handshake, lowest index first.
- Sits between request/flag collectors and index-driven consumers (e.g. a decoder-driven select); turns a multi-hot vector into a serial index stream.

---
 rtl/onehot_scan_encoder.sv | 114 +++++++++++
 1 files changed

// File: rtl/onehot_scan_encoder.sv
// rtl/onehot_scan_encoder.sv - multi-hot request vector to serial index stream
//
// Accepts a WIDTH-bit request vector and emits the binary index of each set
// bit, one per output handshake. Default order is lowest index first; define
// ONEHOT_SCAN_MSB_FIRST_EN to emit highest index first instead.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   in_vec is valid
//   in_ready   block can accept a vector this cycle
//   in_vec     request vector, any pattern legal (zero is consumed silently)
//   out_valid  out_idx is valid
//   out_ready  downstream accepts the current beat
//   out_idx    index of the currently selected set bit
//   out_last   current beat is the final index of the vector
//   out_cnt    indices still pending, including the current one
//   busy       a vector is being scanned

module onehot_scan_encoder #(
    parameter int WIDTH = 8,
    parameter int IDXW  = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IDXW-1:0] out_idx,
    output logic            out_last,
    output logic [IDXW:0]   out_cnt,
    output logic            busy
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d;

    logic [IDXW-1:0]  sel_idx;
    logic [WIDTH-1:0] sel_mask;
    logic [IDXW:0]    pop_cnt;
    logic             scanning;
    logic             beat_done;
    logic             in_fire;

    // Priority select over the pending bits. The loop runs toward the
    // preferred end so the last match wins.
    always_comb begin
        sel_idx = '0;
`ifdef ONEHOT_SCAN_MSB_FIRST_EN
        for (int i = 0; i < WIDTH; i++) begin
            if (pending_q[i]) sel_idx = IDXW'(i);
        end
`else
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pending_q[i]) sel_idx = IDXW'(i);
        end
`endif
    end

    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop_cnt = pop_cnt + (IDXW + 1)'(pending_q[i]);
        end
    end

    assign sel_mask  = WIDTH'(1) << sel_idx;
    assign scanning  = (state_q == ST_SCAN);

    // Outputs come from registered state only; pending is zero in IDLE so
    // out_idx and out_cnt read 0 there without extra gating.
    assign out_valid = scanning;
    assign busy      = scanning;
    assign out_idx   = sel_idx;
    assign out_cnt   = pop_cnt;
    assign out_last  = scanning && (pop_cnt == (IDXW + 1)'(1));
    assign beat_done = out_valid && out_ready;

    // A new vector may land on the cycle the previous one's last beat leaves.
    assign in_ready  = !rst && (!scanning || (beat_done && out_last));
    assign in_fire   = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        if (beat_done) begin
            pending_d = pending_q & ~sel_mask;
            if (out_last) state_d = ST_IDLE;
        end
        if (in_fire) begin
            // A zero vector is consumed with no beat; pending is already
            // empty here because acceptance only happens when idle or on
            // the final beat.
            pending_d = in_vec;
            state_d   = (in_vec != '0) ? ST_SCAN : ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

endmodule
